// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the multicycle sequencer (master) and the datapath (slave).
interface multicycle_control_fsm_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        mem_ready;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [2:0]  ImmSrc;
  logic        illegal_instr;
  logic [3:0]  state;

  modport master (
    input  Instr, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, illegal_instr, state
  );

  modport slave (
    output Instr, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, illegal_instr, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multicycle RV32I-subset core: walks each instruction through
// fetch/decode/execute/writeback and drives datapath selects, enables and the ALU code.
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit SLT_EN        = 1'b1
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StJalrWb   = 4'd12
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;

  state_e state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       ready;
  logic       unused_bits;

  assign opcode      = bus.Instr[6:0];
  assign funct3      = bus.Instr[14:12];
  assign funct7      = bus.Instr[31:25];
  assign ready       = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign unused_bits = ^{bus.Instr[24:15], bus.Instr[11:7]};

  // R/I-type funct legality is resolved here so illegal encodings never reach execute.
  logic r_legal, i_legal;
  always_comb begin
    r_legal = 1'b0;
    unique case (funct3)
      3'b000:         r_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      3'b110, 3'b111: r_legal = (funct7 == 7'b0000000);
      3'b010:         r_legal = SLT_EN && (funct7 == 7'b0000000);
      default:        r_legal = 1'b0;
    endcase
    i_legal = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  logic       pc_update, branch;
  logic       adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, src_a, src_b;
  logic [2:0] alu_ctrl, imm_src;

  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_ctrl   = 3'b000;
    imm_src    = 3'b000;

    case (state_q)
      StFetch: begin
        src_b      = 2'b10;
        result_src = 2'b10;
        ir_write   = ready;
        pc_update  = ready;
        if (ready) state_d = StDecode;
      end
      StDecode: begin
        src_a   = 2'b01;
        src_b   = 2'b01;
        imm_src = (opcode == OpJal) ? 3'b011 : 3'b010;
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:    if (r_legal) state_d = StExecR; else begin state_d = StFetch; illegal = 1'b1; end
          OpI:    if (i_legal) state_d = StExecI; else begin state_d = StFetch; illegal = 1'b1; end
          OpLui:  state_d = StExecI;
          OpBeq:  state_d = StBeq;
          OpJal:  state_d = StJal;
          OpJalr: state_d = StJalr;
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        imm_src = (opcode == OpStore) ? 3'b001 : 3'b000;
        state_d = (opcode == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src = 1'b1;
        if (ready) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (ready) state_d = StFetch;
      end
      StExecR: begin
        src_a = 2'b10;
        case (funct3)
          3'b000:  alu_ctrl = (funct7 == 7'b0100000) ? 3'b001 : 3'b000;
          3'b110:  alu_ctrl = 3'b011;
          3'b111:  alu_ctrl = 3'b010;
          3'b010:  alu_ctrl = 3'b101;
          default: alu_ctrl = 3'b000;
        endcase
        state_d = StAluWb;
      end
      StExecI: begin
        src_a = 2'b10;
        src_b = 2'b01;
        if (opcode == OpLui) begin
          imm_src  = 3'b100;
          alu_ctrl = 3'b100;
        end else begin
          case (funct3)
            3'b110:  alu_ctrl = 3'b011;
            3'b111:  alu_ctrl = 3'b010;
            default: alu_ctrl = 3'b000;
          endcase
        end
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBeq: begin
        src_a    = 2'b10;
        alu_ctrl = 3'b001;
        branch   = 1'b1;
        state_d  = StFetch;
      end
      StJal: begin
        // PC <= target latched in ALUOut during decode; OldPC+4 rides to ALUWB.
        src_a     = 2'b01;
        src_b     = 2'b10;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StJalr: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = StJalrWb;
      end
      StJalrWb: begin
        src_a      = 2'b01;
        src_b      = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Reset forces every output low so an aborted access issues no further strobes.
  always_comb begin
    bus.PCWrite       = ~reset & (pc_update | (branch & bus.Zero));
    bus.AdrSrc        = ~reset & adr_src;
    bus.MemWrite      = ~reset & mem_write;
    bus.IRWrite       = ~reset & ir_write;
    bus.RegWrite      = ~reset & reg_write;
    bus.illegal_instr = ~reset & illegal;
    bus.ResultSrc     = reset ? 2'b00 : result_src;
    bus.ALUSrcA       = reset ? 2'b00 : src_a;
    bus.ALUSrcB       = reset ? 2'b00 : src_b;
    bus.ALUControl    = reset ? 3'b000 : alu_ctrl;
    bus.ImmSrc        = reset ? 3'b000 : imm_src;
    bus.state         = reset ? 4'd0 : state_q;
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-instruction state/strobe traces vs hand values.
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus_if ();
  multicycle_control_fsm_if bus2_if ();

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1), .SLT_EN(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1), .SLT_EN(1'b0)) dut_noslt (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2_if)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Per-cycle trace of the last instruction, bit i = cycle i.
  logic [3:0]  st [20];
  logic [2:0]  alu [20];
  logic [19:0] rw_m, mw_m, pw_m, as_m, il_m;
  int          ncyc;

  // Starts with state==FETCH; mem_ready held low for wait_n cycles once in MEMREAD/MEMWRITE.
  task automatic run_instr(input logic [31:0] instr, input logic zero, input int wait_n);
    int left;
    left = wait_n;
    bus_if.Instr = instr;
    bus_if.Zero  = zero;
    rw_m = '0; mw_m = '0; pw_m = '0; as_m = '0; il_m = '0;
    ncyc = 0;
    for (int i = 0; i < 20; i++) begin
      if ((bus_if.state == 4'd3 || bus_if.state == 4'd5) && left > 0) begin
        bus_if.mem_ready = 1'b0;
        left--;
      end else begin
        bus_if.mem_ready = 1'b1;
      end
      #1;
      st[i]   = bus_if.state;
      alu[i]  = bus_if.ALUControl;
      rw_m[i] = bus_if.RegWrite;
      mw_m[i] = bus_if.MemWrite;
      pw_m[i] = bus_if.PCWrite;
      as_m[i] = bus_if.AdrSrc;
      il_m[i] = bus_if.illegal_instr;
      tick();
      if (bus_if.state == 4'd0) begin
        ncyc = i + 1;
        break;
      end
    end
    if (ncyc == 0) check("instr_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bus_if.Instr = 32'h0; bus_if.Zero = 1'b0; bus_if.mem_ready = 1'b1;
    bus2_if.Instr = 32'h0020A1B3; bus2_if.Zero = 1'b0; bus2_if.mem_ready = 1'b1;

    // Reset: FETCH but every output gated low.
    tick();
    check("rst_state", {28'd0, bus_if.state}, 32'd0);
    check("rst_irwrite", {31'd0, bus_if.IRWrite}, 32'd0);
    check("rst_srcb", {30'd0, bus_if.ALUSrcB}, 32'd0);
    check("rst_pcwrite", {31'd0, bus_if.PCWrite}, 32'd0);

    bus_if.Instr = 32'h002081B3;
    reset = 1'b0;
    #1;
    check("fetch_irwrite", {31'd0, bus_if.IRWrite}, 32'd1);
    check("fetch_srcb", {30'd0, bus_if.ALUSrcB}, 32'd2);
    check("fetch_ressrc", {30'd0, bus_if.ResultSrc}, 32'd2);

    // add x3,x1,x2
    run_instr(32'h002081B3, 1'b0, 0);
    check("add_cpi", ncyc, 4);
    check("add_states", {16'd0, st[0], st[1], st[2], st[3]}, 32'h0168);
    check("add_alu", {29'd0, alu[2]}, 32'd0);
    check("add_rw", {12'd0, rw_m}, 32'b1000);

    run_instr(32'h402081B3, 1'b0, 0);
    check("sub_alu", {29'd0, alu[2]}, 32'd1);
    run_instr(32'h0020A1B3, 1'b0, 0);
    check("slt_alu", {29'd0, alu[2]}, 32'd5);
    check("slt_state", {28'd0, st[2]}, 32'd6);

    run_instr(32'h00108093, 1'b0, 0);
    check("addi_states", {16'd0, st[0], st[1], st[2], st[3]}, 32'h0178);
    run_instr(32'h0010E093, 1'b0, 0);
    check("ori_alu", {29'd0, alu[2]}, 32'd3);
    run_instr(32'h000010B7, 1'b0, 0);
    check("lui_alu", {29'd0, alu[2]}, 32'd4);

    // lw with 3 wait cycles in MEMREAD
    run_instr(32'h0000A283, 1'b0, 3);
    check("lw_cpi", ncyc, 8);
    check("lw_states", {st[0], st[1], st[2], st[3], st[4], st[5], st[6], st[7]}, 32'h01233334);
    check("lw_rw", {12'd0, rw_m}, 32'b1000_0000);
    check("lw_adr", {12'd0, as_m}, 32'b0111_1000);

    // sw with 2 wait cycles in MEMWRITE
    run_instr(32'h0050A023, 1'b0, 2);
    check("sw_cpi", ncyc, 6);
    check("sw_mw", {12'd0, mw_m}, 32'b11_1000);
    check("sw_adr", {12'd0, as_m}, 32'b11_1000);
    check("sw_rw", {12'd0, rw_m}, 32'd0);

    run_instr(32'h00208063, 1'b1, 0);
    check("beq_t_cpi", ncyc, 3);
    check("beq_t_state", {28'd0, st[2]}, 32'd9);
    check("beq_t_pw", {12'd0, pw_m}, 32'b101);
    run_instr(32'h00208063, 1'b0, 0);
    check("beq_nt_pw", {12'd0, pw_m}, 32'b001);

    run_instr(32'h000000EF, 1'b0, 0);
    check("jal_states", {16'd0, st[0], st[1], st[2], st[3]}, 32'h01A8);
    check("jal_pw", {12'd0, pw_m}, 32'b0101);
    check("jal_rw", {12'd0, rw_m}, 32'b1000);

    run_instr(32'h000100E7, 1'b0, 0);
    check("jalr_states", {16'd0, st[0], st[1], st[2], st[3]}, 32'h01BC);
    check("jalr_pw", {12'd0, pw_m}, 32'b0101);
    check("jalr_rw", {12'd0, rw_m}, 32'b1000);

    run_instr(32'h00000000, 1'b0, 0);
    check("ill_cpi", ncyc, 2);
    check("ill_pulse", {12'd0, il_m}, 32'b10);
    check("ill_rw", {12'd0, rw_m}, 32'd0);

    // Reset during MEMWRITE drops the strobe in the same cycle.
    bus_if.Instr = 32'h0050A023;
    bus_if.mem_ready = 1'b1;
    for (int i = 0; i < 10 && bus_if.state != 4'd5; i++) begin
      tick();
      if (bus_if.state == 4'd5) bus_if.mem_ready = 1'b0;
    end
    bus_if.mem_ready = 1'b0;
    #1;
    check("mw_before_rst", {31'd0, bus_if.MemWrite}, 32'd1);
    reset = 1'b1;
    #1;
    check("mw_at_rst", {31'd0, bus_if.MemWrite}, 32'd0);
    check("state_at_rst", {28'd0, bus_if.state}, 32'd0);

    // SLT_EN=0 instance: slt is illegal, decode pulses and returns to FETCH.
    bus_if.mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("noslt_state", {28'd0, bus2_if.state}, 32'd1);
    check("noslt_illegal", {31'd0, bus2_if.illegal_instr}, 32'd1);
    check("noslt_rw", {31'd0, bus2_if.RegWrite}, 32'd0);
    tick();
    check("noslt_back", {28'd0, bus2_if.state}, 32'd0);
    check("noslt_pulse_end", {31'd0, bus2_if.illegal_instr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
